// File: rtl/spi_dac_writer.sv
// spi_dac_writer
//   SPI master (mode 0) for multi-channel serial DACs. Each accepted write is
//   sent as one frame {chan, CFG_WORD, data}, MSB first, framed by cs_n. After
//   the frame it can optionally pulse ldac_n so the DAC latches the new code.
//
// Ports
//   clk, rst              system clock, synchronous active-high reset
//   in_valid / in_ready   write handshake; in_ready is high only when idle
//   in_chan, in_data      target channel and DAC code
//   in_ldac               pulse ldac_n after this frame
//   busy                  a write is in progress
//   done                  1-cycle pulse when the unit returns to idle after a frame
//   err                   1-cycle pulse when in_chan is out of range (write dropped)
//   cs_n, sclk, sdo       SPI pins (sclk idles low, sdo changes on the falling edge)
//   ldac_n                DAC latch strobe, active low

module spi_dac_writer #(
  parameter int CHANNELS    = 2,
  parameter int DATA_BITS   = 12,
  parameter int CFG_BITS    = 3,
  parameter logic [CFG_BITS-1:0] CFG_WORD = 3'b011,
  parameter int HALF_CYCLES = 1,
  parameter int CSS_CYCLES  = 1,
  parameter int CSH_CYCLES  = 2,
  parameter int LDAC_CYCLES = 1,
  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [CH_W-1:0]      in_chan,
  input  logic [DATA_BITS-1:0] in_data,
  input  logic                 in_ldac,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic                 cs_n,
  output logic                 sclk,
  output logic                 sdo,
  output logic                 ldac_n
);

  localparam int FRAME_BITS = CH_W + CFG_BITS + DATA_BITS;

  // One shared phase counter serves every timed state, so it is sized for the
  // longest of them. It always restarts at zero on a state change.
  localparam int MAX_1   = (CSS_CYCLES > HALF_CYCLES) ? CSS_CYCLES : HALF_CYCLES;
  localparam int MAX_2   = (CSH_CYCLES > LDAC_CYCLES) ? CSH_CYCLES : LDAC_CYCLES;
  localparam int MAX_CYC = (MAX_1 > MAX_2) ? MAX_1 : MAX_2;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam int BIT_W   = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;

  localparam logic [CNT_W-1:0] CSS_LAST  = CNT_W'(CSS_CYCLES - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CYCLES - 1);
  localparam logic [CNT_W-1:0] CSH_LAST  = CNT_W'(CSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] LDAC_LAST = CNT_W'(LDAC_CYCLES - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(FRAME_BITS - 1);
  localparam logic [CH_W:0]    CHAN_LIMIT = (CH_W + 1)'(CHANNELS);

  typedef enum logic [2:0] {IDLE, CSS, LOW, HIGH, CSH, LDAC} state_t;

  state_t                  state, next_state;
  logic [CNT_W-1:0]        cnt;
  logic [BIT_W-1:0]        bit_idx;
  logic [FRAME_BITS-1:0]   shreg;
  logic                    ldac_req;
  logic                    accept;
  logic                    chan_bad;
  logic                    cnt_last;
  logic                    load;
  logic                    shift;

  // Handshake decode. The channel check is done one bit wider than in_chan so
  // that a CHANNELS value of exactly 2**CH_W still compares correctly.
  always_comb begin
    accept   = in_valid && (state == IDLE);
    chan_bad = {1'b0, in_chan} >= CHAN_LIMIT;
    load     = accept && !chan_bad;
  end

  // Terminal count of the phase counter for whichever timed state we are in.
  always_comb begin
    cnt_last = 1'b0;
    case (state)
      CSS:       cnt_last = (cnt == CSS_LAST);
      LOW, HIGH: cnt_last = (cnt == HALF_LAST);
      CSH:       cnt_last = (cnt == CSH_LAST);
      LDAC:      cnt_last = (cnt == LDAC_LAST);
      default:   cnt_last = 1'b0;
    endcase
  end

  // Next-state logic: a frame is CSS, then LOW/HIGH per bit, then CSH and an
  // optional LDAC strobe before returning to IDLE.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (load) next_state = CSS;
      CSS:  if (cnt_last) next_state = LOW;
      LOW:  if (cnt_last) next_state = HIGH;
      HIGH: if (cnt_last) next_state = (bit_idx == BIT_LAST) ? CSH : LOW;
      CSH:  if (cnt_last) next_state = ldac_req ? LDAC : IDLE;
      LDAC: if (cnt_last) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // The shift happens only on HIGH->LOW, so the first bit is presented at CSS
  // entry and each later bit moves on the SCLK falling edge.
  assign shift = (state == HIGH) && cnt_last && (bit_idx != BIT_LAST);

  // State register plus the datapath registers and the done/err pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      ldac_req <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state <= next_state;
      cnt   <= (next_state != state) ? '0 : cnt + 1'b1;
      done  <= (state != IDLE) && (next_state == IDLE);
      err   <= accept && chan_bad;
      if (load) begin
        shreg    <= {in_chan, CFG_WORD, in_data};
        ldac_req <= in_ldac;
        bit_idx  <= '0;
      end else if (shift) begin
        shreg   <= {shreg[FRAME_BITS-2:0], 1'b0};
        bit_idx <= bit_idx + 1'b1;
      end
    end
  end

  // Pin outputs are pure functions of the state so they change on the same
  // edge as the state itself.
  always_comb begin
    in_ready = (state == IDLE);
    busy     = (state != IDLE);
    cs_n     = !((state == CSS) || (state == LOW) || (state == HIGH));
    sclk     = (state == HIGH);
    sdo      = cs_n ? 1'b0 : shreg[FRAME_BITS-1];
    ldac_n   = (state != LDAC);
  end

endmodule
